// File: rtl/instr_mem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the program is in place.
module instr_mem_loader #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_reload,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_core_rst,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [23:0] r_asm;
  logic [31:0] r_n;
  logic [31:0] r_k;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wd;
  logic        r_in_ready;
  logic        r_core_rst;
  logic        r_done;
  logic        r_err;

  state_t      w_state_nxt;
  logic [1:0]  w_lane_nxt;
  logic [23:0] w_asm_nxt;
  logic [31:0] w_n_nxt;
  logic [31:0] w_k_nxt;
  logic        w_we_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_wd_nxt;
  logic        w_accept;
  logic [31:0] w_word;
  logic        w_done_nxt;

  // Lane 3 is never stored: the word completes combinationally with the incoming byte.
  assign w_accept = i_in_valid & r_in_ready;
  assign w_word   = {i_in_data, r_asm};

  // Next-state and next-value logic for the loader FSM and its datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_asm_nxt   = r_asm;
    w_n_nxt     = r_n;
    w_k_nxt     = r_k;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_wd_nxt    = r_mem_wd;
    case (r_state)
      S_HDR, S_LOAD: begin
        if (w_accept) begin
          w_lane_nxt = r_lane + 2'd1;
          case (r_lane)
            2'd0:    w_asm_nxt[7:0]   = i_in_data;
            2'd1:    w_asm_nxt[15:8]  = i_in_data;
            2'd2:    w_asm_nxt[23:16] = i_in_data;
            default: w_asm_nxt        = r_asm;
          endcase
          if (r_lane == 2'd3) begin
            if (r_state == S_HDR) begin
              w_n_nxt = w_word;
              w_k_nxt = 32'd0;
              if (w_word == 32'd0) begin
                w_state_nxt = S_DONE;
              end else if (w_word > DEPTH_W) begin
                w_state_nxt = S_ERR;
              end else begin
                w_state_nxt = S_LOAD;
              end
            end else begin
              w_we_nxt   = 1'b1;
              w_addr_nxt = r_k << 2;
              w_wd_nxt   = w_word;
              w_k_nxt    = r_k + 32'd1;
              if (r_k == r_n - 32'd1) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_LOAD;
              end
            end
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DONE, S_ERR: begin
        if (i_reload) begin
          w_state_nxt = S_HDR;
          w_lane_nxt  = 2'd0;
          w_k_nxt     = 32'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // The core is released only once the final write pulse has been issued.
  assign w_done_nxt = (w_state_nxt == S_DONE) && !w_we_nxt;

  // State, datapath and registered outputs; reset overrides everything including a pending write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_HDR;
      r_lane     <= 2'd0;
      r_asm      <= 24'd0;
      r_n        <= 32'd0;
      r_k        <= 32'd0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 32'd0;
      r_mem_wd   <= 32'd0;
      r_in_ready <= 1'b1;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane     <= w_lane_nxt;
      r_asm      <= w_asm_nxt;
      r_n        <= w_n_nxt;
      r_k        <= w_k_nxt;
      r_mem_we   <= w_we_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_wd   <= w_wd_nxt;
      r_in_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_LOAD);
      r_core_rst <= !w_done_nxt;
      r_done     <= w_done_nxt;
      r_err      <= (w_state_nxt == S_ERR);
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wd   = r_mem_wd;
  assign o_core_rst = r_core_rst;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: byte-count reference model compared every cycle,
// plus directed streams with literal expectations on writes and done/err timing.
module tb_instr_mem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;
  logic        in_ready, mem_we, core_rst, done, err;
  logic [31:0] mem_addr, mem_wd;

  int checks = 0;
  int failures = 0;

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_reload(reload), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_core_rst(core_rst),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: counts accepted bytes of the current stream.
  // status 0 = accepting, 1 = program stored, 2 = header rejected.
  int          m_status = 0;
  longint      m_cnt = 0;
  longint      m_n = 0;
  logic [31:0] m_word = 32'd0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wd = 32'd0;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_status = 0; m_cnt = 0; m_n = 0; m_word = 32'd0;
      m_we = 1'b0; m_addr = 32'd0; m_wd = 32'd0; m_started = 1'b1;
    end else begin
      m_we = 1'b0;
      if (m_status == 0 && in_valid) begin
        m_word = m_word | (32'(in_data) << (8 * (m_cnt % 4)));
        m_cnt++;
        if (m_cnt % 4 == 0) begin
          if (m_cnt == 4) begin
            m_n = longint'(m_word);
            if (m_n == 0) m_status = 1;
            else if (m_n > DEPTH) m_status = 2;
          end else begin
            m_we = 1'b1;
            m_addr = 32'((m_cnt / 4 - 2) * 4);
            m_wd = m_word;
            if (m_cnt == 4 + 4 * m_n) m_status = 1;
          end
          m_word = 32'd0;
        end
      end else if (m_status != 0 && reload) begin
        m_status = 0; m_cnt = 0; m_word = 32'd0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 32'(in_ready), 32'(m_status == 0));
      chk("mem_we",   32'(mem_we),   32'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wd",   mem_wd,   m_wd);
      chk("err",      32'(err),      32'(m_status == 2));
      chk("done",     32'(done),     32'(m_status == 1 && !m_we));
      chk("core_rst", 32'(core_rst), 32'(!(m_status == 1 && !m_we)));
    end
  end

  logic [63:0] wlog[$];
  always @(negedge clk) if (mem_we) wlog.push_back({mem_addr, mem_wd});

  task automatic send(input logic [7:0] b, input int gap);
    in_data = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_prog(input int gap);
    logic [7:0] s [12];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    for (int i = 0; i < 12; i++) send(s[i], (i == 11) ? 0 : gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  // Called right after the last byte's edge: write in the next cycle, done one cycle later.
  task automatic check_final(input string nm, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk({nm, "_last_we"}, 32'(mem_we), 32'd1);
    chk({nm, "_last_addr"}, mem_addr, addr);
    chk({nm, "_last_wd"}, mem_wd, wd);
    chk({nm, "_done_early"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_core_rst"}, 32'(core_rst), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word program, full rate
    send_prog(0);
    check_final("t1", 32'h4, 32'h00B00593);
    chk("t1_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk("t1_w0", wlog[0][31:0], 32'h00A00513);
      chk("t1_a0", wlog[0][63:32], 32'h0);
      chk("t1_w1", wlog[1][31:0], 32'h00B00593);
    end

    // Same program with a gap after every byte
    pulse_reload();
    send_prog(1);
    check_final("t2", 32'h4, 32'h00B00593);
    chk("t2_nwrites", 32'(wlog.size()), 32'd4);
    if (wlog.size() >= 4) begin
      chk("t2_w0", wlog[2][31:0], 32'h00A00513);
      chk("t2_a1", wlog[3][63:32], 32'h4);
    end

    // Oversized header N=1025
    pulse_reload();
    send(8'h01, 0); send(8'h04, 0); send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t3_core_rst", 32'(core_rst), 32'd1);
    chk("t3_nwrites", 32'(wlog.size()), 32'd4);
    @(posedge clk); #1;
    pulse_reload();
    @(negedge clk);
    chk("t3_reload_ready", 32'(in_ready), 32'd1);
    chk("t3_reload_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Empty program N=0
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_core_rst", 32'(core_rst), 32'd0);
    @(posedge clk); #1;
    pulse_reload();
    @(negedge clk);
    chk("t4_reload_core_rst", 32'(core_rst), 32'd1);
    chk("t4_reload_done", 32'(done), 32'd0);
    chk("t4_reload_ready", 32'(in_ready), 32'd1);
    chk("t4_nwrites", 32'(wlog.size()), 32'd4);
    @(posedge clk); #1;

    // Reset on the edge that completes word 3 of a four-word program
    send(8'h04, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    for (int i = 0; i < 15; i++) send(8'(8'h10 + i), 0);
    base = wlog.size();
    chk("t5_pre_nwrites", 32'(base), 32'd7);
    in_data = 8'h5A; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("t5_no_we", 32'(mem_we), 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    send_prog(0);
    check_final("t5", 32'h4, 32'h00B00593);
    chk("t5_nwrites", 32'(wlog.size()), 32'd9);
    if (wlog.size() >= 9) chk("t5_a0", wlog[7][63:32], 32'h0);

    // Bytes offered in DONE are refused; reload+valid consumes the byte next cycle
    in_data = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("t6_hdr_ok", 32'(done | err), 32'd0);
    @(posedge clk); #1;
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    check_final("t6", 32'h0, 32'hEFBEADDE);
    chk("t6_nwrites", 32'(wlog.size()), 32'd10);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader for the single-cycle core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially into the instruction memory's write port and holds the core in reset until the whole program is stored. It is the writer side of the instruction memory that the core's fetch path reads.

## Interface
- DEPTH, 1024, instruction memory capacity in 32-bit words; the program word count must not exceed it.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to load a new program; honoured only in DONE or ERR.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the word being written, always word-aligned.
- mem_wd  output  32  word being written.
- core_rst  output  1  reset to the core (PC, register file); high while loading.
- done  output  1  program fully written.
- err  output  1  header word count exceeded DEPTH.

## Operation
- Stream format: 4-byte header holding the word count N, least significant byte first, followed by N words of 4 bytes each, also least significant byte first.
- Transfer rule: a byte is consumed on a rising edge where in_valid && in_ready. A byte is never consumed when in_ready is 0.
- States:
  - HDR: collect 4 header bytes.
  - LOAD: collect program words.
  - DONE: program loaded.
  - ERR: header rejected.
- Byte-lane counter (2 bits) selects the target byte of the assembly register: lane 0 → bits [7:0], up to lane 3 → bits [31:24]. It wraps 3→0 on each completed word or header.
- HDR, 4th byte accepted:
  - N == 0 → go to DONE.
  - N > DEPTH → go to ERR.
  - Otherwise → go to LOAD with word index k = 0.
- LOAD, 4th byte of word k accepted:
  - Next cycle: mem_we=1, mem_wd = assembled word, mem_addr = 4*k (k zero-extended to 32 bits, shifted left 2).
  - k increments.
  - If k was N-1, the state becomes DONE on that same edge.
- in_ready: 1 in HDR and LOAD, 0 in DONE and ERR.
- Back-to-back bytes are accepted with no bubbles. A write pulse does not stall input.
- core_rst: 1 in HDR, LOAD and ERR, and during the cycle of the final mem_we pulse. It drops to 0 the cycle after the final write, so the first fetch sees the written memory.
- done: high exactly when core_rst has dropped after a successful load. err: high in ERR.
- reload in DONE or ERR:
  - Go to HDR.
  - Clear k and the lane counter.
  - Assert core_rst on the next cycle.
  - Deassert done and err.
- reload in HDR or LOAD is ignored.
- Stalls: in_valid may drop at any byte boundary or mid-word. Partially assembled bytes and the lane counter are held indefinitely.
- Bytes arriving after DONE are not consumed (in_ready=0).

## Timing
- Values after reset, and during rst high:
  - state HDR, in_ready=1, core_rst=1.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - done=0, err=0.
  - lane=0, k=0.
- rst wins over every other input, including mid-word and mid-write. A pending mem_we is cancelled, not issued.
- Latency: last byte of a word accepted at edge t → mem_we high during cycle t+1.
- Final word: mem_we high during cycle t+1 → core_rst=0 and done=1 from cycle t+2.
- Minimum load time for N words at full rate: 4 + 4N accepting cycles, plus 2 cycles to done.
- mem_addr and mem_wd are registered and stable for the whole mem_we cycle. Both hold their last value when mem_we=0.
- HDR→DONE for N=0: done=1 and core_rst=0 the cycle after the 4th header byte.

## Test plan
- Reset, then header 02 00 00 00, then bytes 13 05 A0 00, 93 05 B0 00 back-to-back:
  - mem_we pulses with addr 0x0 / data 0x00A00513 and addr 0x4 / data 0x00B00593.
  - done=1 and core_rst=0 two cycles after the last byte.
- Same stream with in_valid toggling every other cycle, including gaps mid-word: identical writes; the stall pattern affects only latency.
- Header 01 04 00 00 (N=1025) with DEPTH=1024:
  - err=1 and in_ready=0 next cycle.
  - No mem_we ever.
  - core_rst stays 1.
  - reload returns to HDR.
- Header of N=0 → done=1 the next cycle, no writes. A subsequent reload pulse → core_rst=1, done=0, in_ready=1.
- rst asserted the same edge the 4th byte of word 3 is accepted: no mem_we the next cycle. After release, a full new stream loads from addr 0x0.
- Byte offered while in DONE: in_ready=0 and the byte is not consumed. reload together with in_valid in DONE: the byte is not consumed that cycle and is consumed as header lane 0 the next cycle.
